// File: rtl/f1_pkg.sv
// Shared types and limits for the F1 start-light sequencer family.
package f1_pkg;

    // Sequencer phases: idle, lamps filling, all lamps held, go pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        GO   = 2'd3
    } f1_state_t;

    // Widest lamp bank any sequencer instance may drive.
    localparam int F1_MAX_LIGHTS = 32;

endpackage : f1_pkg

// File: rtl/f1_rise_detect.sv
// Rising-edge detector: one flop with a configurable reset value plus an AND.
// A reset value of 1 means a level already high when reset releases is not
// treated as an edge.
module f1_rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // Track the previous level of the input every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule : f1_rise_detect

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills NUM_LIGHTS lamps one per strobe as a
// thermometer code, holds them for an externally timed random delay, then
// extinguishes them and pulses the go signal to the reaction timer.
module f1_light_seq
    import f1_pkg::*;
#(
    parameter int NUM_LIGHTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  trigger,
    input  logic                  delay_done,
    output logic [NUM_LIGHTS-1:0] data_out,
    output logic                  cmd_seq,
    output logic                  cmd_delay,
    output logic                  lights_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(NUM_LIGHTS + 1);
    localparam logic [CNT_W-1:0] LAST_LAMP = CNT_W'(NUM_LIGHTS - 1);
    localparam logic [CNT_W-1:0] ALL_LIT   = CNT_W'(NUM_LIGHTS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_LIGHTS:0] WIDE_ONE = {{NUM_LIGHTS{1'b0}}, 1'b1};

    if (NUM_LIGHTS < 1 || NUM_LIGHTS > F1_MAX_LIGHTS) begin : g_bad_num_lights
        $error("f1_light_seq: NUM_LIGHTS must be within 1..%0d", F1_MAX_LIGHTS);
    end

    f1_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;
    logic             w_rise;
    logic             w_therm_msb_unused;
    logic [NUM_LIGHTS-1:0] w_therm;

    // Trigger edge detector; its flop resets high so a held trigger is not a start.
    f1_rise_detect #(
        .RST_VAL (1'b1)
    ) u_trig_rise (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (trigger),
        .o_rise  (w_rise)
    );

    // Thermometer is built one bit wider than the lamp bank so that a full
    // count (1 << NUM_LIGHTS) does not wrap before the subtract.
    assign {w_therm_msb_unused, w_therm} = (WIDE_ONE << r_cnt) - WIDE_ONE;

    // Sequencer state, lit-lamp count and first-HOLD-cycle flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_first <= 1'b0;
                    if (w_rise) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (en) begin
                        if (r_cnt == LAST_LAMP) begin
                            r_cnt   <= ALL_LIT;
                            r_first <= 1'b1;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    r_first <= 1'b0;
                    if (delay_done) begin
                        r_state <= GO;
                    end
                end
                GO: begin
                    r_cnt   <= '0;
                    r_first <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_first <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode from the state register and the lit count.
    always_comb begin
        data_out   = '0;
        cmd_seq    = 1'b0;
        cmd_delay  = 1'b0;
        lights_out = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            FILL: begin
                data_out = w_therm;
                cmd_seq  = 1'b1;
            end
            HOLD: begin
                data_out  = '1;
                cmd_delay = r_first;
            end
            GO: begin
                lights_out = 1'b1;
            end
            default: begin
                data_out = '0;
            end
        endcase
    end

endmodule : f1_light_seq

// File: tb/tb_f1_light_seq.sv
// Directed bench for f1_light_seq at NUM_LIGHTS = 8, 4 and 1.
module tb_f1_light_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       en8 = 1'b0, trig8 = 1'b0, dd8 = 1'b0;
    logic [7:0] d8;
    logic       seq8, dly8, go8, busy8;

    logic       en4 = 1'b0, trig4 = 1'b0, dd4 = 1'b0;
    logic [3:0] d4;
    logic       seq4, dly4, go4, busy4;

    logic       en1 = 1'b0, trig1 = 1'b0, dd1 = 1'b0;
    logic [0:0] d1;
    logic       seq1, dly1, go1, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    f1_light_seq #(.NUM_LIGHTS(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .trigger(trig8), .delay_done(dd8),
        .data_out(d8), .cmd_seq(seq8), .cmd_delay(dly8), .lights_out(go8), .busy(busy8)
    );

    f1_light_seq #(.NUM_LIGHTS(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en4), .trigger(trig4), .delay_done(dd4),
        .data_out(d4), .cmd_seq(seq4), .cmd_delay(dly4), .lights_out(go4), .busy(busy4)
    );

    f1_light_seq #(.NUM_LIGHTS(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .trigger(trig1), .delay_done(dd1),
        .data_out(d1), .cmd_seq(seq1), .cmd_delay(dly1), .lights_out(go1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_en8();
        en8 = 1'b1;
        tick();
        en8 = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_data", d8, 32'h0);
        check("rst_seq", seq8, 0);
        check("rst_delay", dly8, 0);
        check("rst_go", go8, 0);
        check("rst_busy", busy8, 0);
        rst = 1'b1;
        tick();

        // Basic run, 8 lamps
        trig8 = 1'b1;
        tick();
        check("t1_fill_data", d8, 32'h00);
        check("t1_fill_seq", seq8, 1);
        check("t1_fill_busy", busy8, 1);
        trig8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pulse_en8();
            check($sformatf("t1_data_%0d", i), d8, (32'd1 << i) - 32'd1);
            check($sformatf("t1_seq_%0d", i), seq8, (i < 8) ? 32'd1 : 32'd0);
            if (i < 8) begin
                check($sformatf("t1_nodly_%0d", i), dly8, 0);
                tick();
                tick();
            end
        end
        check("t1_cmd_delay", dly8, 1);
        tick();
        check("t1_cmd_delay_once", dly8, 0);
        tick();
        tick();
        tick();
        dd8 = 1'b1;
        tick();
        dd8 = 1'b0;
        check("t1_go_data", d8, 32'h00);
        check("t1_go_pulse", go8, 1);
        check("t1_go_busy", busy8, 1);
        tick();
        check("t1_idle_go", go8, 0);
        check("t1_idle_busy", busy8, 0);

        // Trigger held across reset release does not start
        trig8 = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("t2_held_busy", busy8, 0);
        check("t2_held_data", d8, 32'h00);
        trig8 = 1'b0;
        tick();
        trig8 = 1'b1;
        tick();
        check("t2_fresh_seq", seq8, 1);

        // Spurious inputs mid-sequence
        pulse_en8();
        pulse_en8();
        pulse_en8();
        check("t3_data_07", d8, 32'h07);
        trig8 = 1'b0;
        tick();
        trig8 = 1'b1;
        tick();
        check("t3_retrig_data", d8, 32'h07);
        check("t3_retrig_seq", seq8, 1);
        dd8 = 1'b1;
        tick();
        dd8 = 1'b0;
        check("t3_dd_fill_data", d8, 32'h07);
        check("t3_dd_fill_seq", seq8, 1);
        for (int i = 0; i < 5; i++) pulse_en8();
        check("t3_full", d8, 32'hFF);
        check("t3_cmd_delay", dly8, 1);
        pulse_en8();
        check("t3_en_hold_data", d8, 32'hFF);
        check("t3_en_hold_dly", dly8, 0);
        tick();
        check("t3_hold_dly", dly8, 0);
        check("t3_hold_busy", busy8, 1);
        dd8 = 1'b1;
        tick();
        dd8 = 1'b0;
        check("t3_go", go8, 1);
        tick();
        check("t3_idle", busy8, 0);

        // Asynchronous reset between edges
        trig8 = 1'b0;
        tick();
        trig8 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) pulse_en8();
        check("t4_data_1f", d8, 32'h1F);
        #4;
        rst = 1'b0;
        #1;
        check("t4_async_data", d8, 32'h00);
        check("t4_async_seq", seq8, 0);
        check("t4_async_busy", busy8, 0);
        #2;
        rst = 1'b1;
        tick();
        check("t4_post_busy", busy8, 0);
        trig8 = 1'b0;
        tick();
        trig8 = 1'b1;
        tick();
        check("t4_restart_data", d8, 32'h00);
        check("t4_restart_seq", seq8, 1);

        // delay_done coincident with cmd_delay, then back-to-back trigger
        for (int i = 0; i < 8; i++) pulse_en8();
        check("t6_cmd_delay", dly8, 1);
        dd8 = 1'b1;
        tick();
        dd8 = 1'b0;
        check("t6_go", go8, 1);
        check("t6_go_data", d8, 32'h00);
        trig8 = 1'b0;
        tick();
        check("t6_go_one_cycle", go8, 0);
        check("t6_idle", busy8, 0);
        trig8 = 1'b1;
        tick();
        check("t6_retrig_seq", seq8, 1);
        check("t6_retrig_data", d8, 32'h00);

        // Four-lamp build
        trig4 = 1'b1;
        tick();
        check("w4_seq", seq4, 1);
        check("w4_data0", d4, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            en4 = 1'b1;
            tick();
            en4 = 1'b0;
            check($sformatf("w4_data_%0d", i), d4, (32'd1 << i) - 32'd1);
        end
        check("w4_cmd_delay", dly4, 1);
        check("w4_seq_off", seq4, 0);
        en4 = 1'b1;
        tick();
        en4 = 1'b0;
        check("w4_no_overflow", d4, 32'hF);
        check("w4_dly_once", dly4, 0);

        // Single-lamp build
        trig1 = 1'b1;
        tick();
        check("w1_data0", d1, 0);
        check("w1_seq", seq1, 1);
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        check("w1_data1", d1, 1);
        check("w1_cmd_delay", dly1, 1);
        check("w1_seq_off", seq1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_f1_light_seq
